// File: rtl/bcd_to_bin_ctrl.sv
// bcd_to_bin_ctrl
// Sequencer for a shift-and-subtract (reverse double-dabble) BCD-to-binary
// datapath. The 4*NDIG+NBIN-bit working register lives outside this block.
// This block strobes that register, tells the external subtract-3 unit which
// digits to correct, validates the BCD input and flags results that do not fit.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   start     conversion request, sampled only in IDLE
//   a         working register contents; BCD field is a[4*NDIG+NBIN-1:NBIN]
//   init      register loads {bcd, NBIN'b0}
//   sh        register shifts right by one
//   sub       register loads the subtract-unit output
//   adj_mask  per-digit subtract-3 enable (bit 0 = least significant digit)
//   busy      high in every state except IDLE
//   done      one-cycle pulse at the end of each conversion
//   err       input held a digit above 9; held until the next accepted start
//   ovf       value exceeds 2^NBIN-1; held until the next accepted start
//
// state  | meaning
// IDLE   | waiting for start
// LOAD   | init strobe, register takes the BCD operand
// CHECK  | reject the operand if any digit is above 9
// SHIFT  | sh strobe, iteration count advances
// ADJ    | subtract 3 from every digit >= 8 (always one cycle)
// FIN    | register ovf from the leftover BCD field
// DONE   | done pulse
module bcd_to_bin_ctrl #(
  parameter int NDIG = 5,
  parameter int NBIN = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [4*NDIG+NBIN-1:0] a,
  output logic                   init,
  output logic                   sh,
  output logic                   sub,
  output logic [NDIG-1:0]        adj_mask,
  output logic                   busy,
  output logic                   done,
  output logic                   err,
  output logic                   ovf
);

  localparam int AW = 4*NDIG + NBIN;
  localparam int CW = $clog2(NBIN + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(NBIN - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_CHECK,
    S_SHIFT,
    S_ADJ,
    S_FIN,
    S_DONE
  } state_t;

  state_t          state, state_nxt;
  logic [CW-1:0]   cnt;
  logic [NDIG-1:0] dig_gt9;
  logic [NDIG-1:0] dig_ge8;
  logic            bcd_nz;
  logic            unused_bin;

  for (genvar g = 0; g < NDIG; g++) begin : g_dig
    assign dig_gt9[g] = (a[NBIN+4*g +: 4] > 4'd9);
    assign dig_ge8[g] = a[NBIN+4*g+3];
  end

  // Anything left in the BCD field after NBIN shifts is weight >= 2^NBIN.
  assign bcd_nz = |a[AW-1:NBIN];

  // The binary field is the datapath's result; the controller never looks at it.
  assign unused_bin = ^a[NBIN-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      err   <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt <= '0;
            err <= 1'b0;
            ovf <= 1'b0;
          end
        end
        S_CHECK: begin
          if (|dig_gt9) err <= 1'b1;
        end
        S_SHIFT: cnt <= cnt + CW'(1);
        S_FIN:   ovf <= bcd_nz;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt = state;
    init      = 1'b0;
    sh        = 1'b0;
    sub       = 1'b0;
    adj_mask  = '0;
    done      = 1'b0;
    busy      = (state != S_IDLE);
    case (state)
      S_IDLE:  if (start) state_nxt = S_LOAD;
      S_LOAD: begin
        init      = 1'b1;
        state_nxt = S_CHECK;
      end
      S_CHECK: state_nxt = (|dig_gt9) ? S_DONE : S_SHIFT;
      S_SHIFT: begin
        sh        = 1'b1;
        state_nxt = (cnt == CNT_LAST) ? S_FIN : S_ADJ;
      end
      S_ADJ: begin
        // Stays one cycle even when nothing needs correcting, so latency is fixed.
        adj_mask  = dig_ge8;
        sub       = |dig_ge8;
        state_nxt = S_SHIFT;
      end
      S_FIN:   state_nxt = S_DONE;
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bcd_to_bin_ctrl.sv
module tb_bcd_to_bin_ctrl;
  localparam int NDIG = 5;
  localparam int NBIN = 16;
  localparam int AW   = 4*NDIG + NBIN;

  logic            clk = 1'b0;
  logic            rst;
  logic            start;
  logic [AW-1:0]   reg_a;
  logic [19:0]     bcd;
  logic            init, sh, sub, busy, done, err, ovf;
  logic [NDIG-1:0] adj_mask;

  int checks = 0;
  int errors = 0;

  bcd_to_bin_ctrl #(.NDIG(NDIG), .NBIN(NBIN)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .a        (reg_a),
    .init     (init),
    .sh       (sh),
    .sub      (sub),
    .adj_mask (adj_mask),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [AW-1:0] sub3(input logic [AW-1:0] v, input logic [NDIG-1:0] m);
    logic [AW-1:0] r;
    r = v;
    for (int i = 0; i < NDIG; i++)
      if (m[i]) r[NBIN+4*i +: 4] = v[NBIN+4*i +: 4] - 4'd3;
    return r;
  endfunction

  // Working register plus behavioural subtract-3 unit.
  always @(posedge clk) begin
    if (init)     reg_a <= {bcd, 16'h0000};
    else if (sh)  reg_a <= reg_a >> 1;
    else if (sub) reg_a <= sub3(reg_a, adj_mask);
  end

  // Launch one conversion; start is also raised at cycles ign1/ign2.
  task automatic run_conv(input logic [19:0] v, input int ign1, input int ign2,
                          output int done_cyc, output int sh_n, output int sub_n,
                          output int bad, output logic busy1, output logic init1);
    done_cyc = -1; sh_n = 0; sub_n = 0; bad = 0; busy1 = 1'b0; init1 = 1'b0;
    @(negedge clk);
    bcd   = v;
    start = 1'b1;
    for (int k = 1; k <= 60; k++) begin
      @(negedge clk);
      start = (k == ign1 || k == ign2);
      if (k == 1) begin busy1 = busy; init1 = init; end
      sh_n  += int'(sh);
      sub_n += int'(sub);
      if ((int'(init) + int'(sh) + int'(sub)) > 1 || (!sub && adj_mask != '0)) bad++;
      if (done) begin done_cyc = k; break; end
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({init, sh, sub, busy, done, err, ovf} !== 7'b0 || adj_mask !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got init/sh/sub/busy/done/err/ovf=%b mask=%b, want all 0",
               {init, sh, sub, busy, done, err, ovf}, adj_mask);
    end
  endtask

  task automatic test_convert(input string name, input logic [19:0] v,
                              input logic [15:0] exp_bin, input logic exp_ovf,
                              input logic chk_bin, input logic exp_nosub);
    int dc, shn, subn, bad;
    logic b1, i1;
    run_conv(v, -1, -1, dc, shn, subn, bad, b1, i1);
    checks++;
    if (dc !== 35) begin errors++; $display("FAIL %s done_cycle: got %0d want 35", name, dc); end
    checks++;
    if (b1 !== 1'b1 || i1 !== 1'b1) begin
      errors++; $display("FAIL %s cycle1_busy_init: got busy=%b init=%b want 1 1", name, b1, i1);
    end
    checks++;
    if (shn !== 16) begin errors++; $display("FAIL %s sh_count: got %0d want 16", name, shn); end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL %s strobe_rules: got %0d bad cycles want 0", name, bad); end
    checks++;
    if (err !== 1'b0 || ovf !== exp_ovf) begin
      errors++; $display("FAIL %s flags: got err=%b ovf=%b want err=0 ovf=%b", name, err, ovf, exp_ovf);
    end
    if (chk_bin) begin
      checks++;
      if (reg_a[15:0] !== exp_bin) begin
        errors++; $display("FAIL %s result: got %h want %h", name, reg_a[15:0], exp_bin);
      end
    end
    if (exp_nosub) begin
      checks++;
      if (subn !== 0) begin errors++; $display("FAIL %s sub_count: got %0d want 0", name, subn); end
    end
  endtask

  task automatic test_overflow_hold;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (ovf !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      errors++; $display("FAIL ovf_hold: got ovf=%b busy=%b done=%b want 1 0 0", ovf, busy, done);
    end
  endtask

  task automatic test_bad_digit;
    int dc, shn, subn, bad;
    logic b1, i1;
    run_conv(20'h1A345, -1, -1, dc, shn, subn, bad, b1, i1);
    checks++;
    if (dc !== 3) begin errors++; $display("FAIL err_done_cycle: got %0d want 3", dc); end
    checks++;
    if (err !== 1'b1 || ovf !== 1'b0) begin
      errors++; $display("FAIL err_flags: got err=%b ovf=%b want 1 0", err, ovf);
    end
    checks++;
    if (shn !== 0 || subn !== 0) begin
      errors++; $display("FAIL err_no_strobes: got sh=%0d sub=%0d want 0 0", shn, subn);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (err !== 1'b1) begin errors++; $display("FAIL err_hold: got %b want 1", err); end
    test_convert("err_clear", 20'h00007, 16'h0007, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_mid_reset;
    int dones;
    @(negedge clk);
    bcd   = 20'h12345;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 2; k <= 10; k++) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    @(negedge clk);
    rst   = 1'b0;
    dones = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      dones += int'(done) + int'(busy);
    end
    checks++;
    if (dones !== 0) begin errors++; $display("FAIL reset_abort: got %0d done/busy cycles want 0", dones); end
    test_convert("after_reset", 20'h00099, 16'h0063, 1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_ignore_start;
    int dc, shn, subn, bad, extra;
    logic b1, i1;
    run_conv(20'h00321, 5, 20, dc, shn, subn, bad, b1, i1);
    checks++;
    if (dc !== 35 || reg_a[15:0] !== 16'h0141) begin
      errors++; $display("FAIL ignore_start: got done=%0d result=%h want 35 0141", dc, reg_a[15:0]);
    end
    extra = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      extra += int'(busy) + int'(done);
    end
    checks++;
    if (extra !== 0) begin errors++; $display("FAIL ignore_relaunch: got %0d busy cycles want 0", extra); end
  endtask

  task automatic test_back_to_back;
    int d1, d2;
    d1 = -1; d2 = -1;
    @(negedge clk);
    bcd   = 20'h12345;
    start = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      @(negedge clk);
      if (done) begin
        if (d1 < 0) begin
          d1 = k;
          checks++;
          if (reg_a[15:0] !== 16'h3039) begin
            errors++; $display("FAIL b2b_first_result: got %h want 3039", reg_a[15:0]);
          end
          bcd = 20'h00042;
        end else begin
          d2 = k;
          start = 1'b0;
          break;
        end
      end
    end
    start = 1'b0;
    checks++;
    if (d1 !== 35 || d2 !== 71) begin
      errors++; $display("FAIL b2b_done_cycles: got %0d %0d want 35 71", d1, d2);
    end
    checks++;
    if (reg_a[15:0] !== 16'h002A) begin
      errors++; $display("FAIL b2b_second_result: got %h want 002a", reg_a[15:0]);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b_stop: got busy=%b want 0", busy); end
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    bcd   = '0;
    reg_a = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    test_reset();
    rst = 1'b0;
    test_convert("bcd_12345", 20'h12345, 16'h3039, 1'b0, 1'b1, 1'b0);
    test_convert("bcd_65535", 20'h65535, 16'hFFFF, 1'b0, 1'b1, 1'b0);
    test_convert("bcd_65536", 20'h65536, 16'h0000, 1'b1, 1'b0, 1'b0);
    test_overflow_hold();
    test_convert("bcd_zero",  20'h00000, 16'h0000, 1'b0, 1'b1, 1'b1);
    test_bad_digit();
    test_mid_reset();
    test_ignore_start();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
